// File: rtl/cnn_img_pkg.sv
// Shared image geometry, pixel type and sequencer state encoding for the
// pixel-ROM streaming controller.
package cnn_img_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam int RC_W    = 5;

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/img_skid_fifo.sv
// Synchronous power-of-2 FIFO holding {pixel, row, col, last} beats; output
// reads as zero while empty so the stream port idles at its reset value.
module img_skid_fifo #(
  parameter  int WIDTH = 19,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // The upstream credit scheme must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/image_stream_ctrl.sv
// Pixel-ROM sequencer: issues raster addresses under FIFO credit and streams
// tagged pixels out. Define IMG_SEL_EN to add img_sel and a wider image-offset rom_addr.
module image_stream_ctrl
  import cnn_img_pkg::*;
#(
  parameter  int ADDR_W     = 10,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
`ifdef IMG_SEL_EN
  localparam int RA_W       = ADDR_W + 7
`else
  localparam int RA_W       = ADDR_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef IMG_SEL_EN
  input  logic [6:0]               img_sel,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [RA_W-1:0]          rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_last,
  output logic [RC_W-1:0]          m_row,
  output logic [RC_W-1:0]          m_col
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_W  = 2 * RC_W + 1;
  localparam int BEAT_W = DATA_W + TAG_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start_acc;
  logic               w_issue;
  logic               w_issue_last;
  logic               w_credit;
  logic               w_beat;
  logic [ADDR_W-1:0]  r_pix_idx;
  logic [RC_W-1:0]    r_iss_row;
  logic [RC_W-1:0]    r_iss_col;
  logic               r_vld_p0;
  logic               r_vld_p1;
  logic [TAG_W-1:0]   r_tag_p0;
  logic [TAG_W-1:0]   r_tag_p1;
  logic [1:0]         w_pending;
  logic [CNT_W:0]     w_inflight;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [BEAT_W-1:0]  w_fifo_din;
  logic [BEAT_W-1:0]  w_fifo_dout;
  logic [RA_W-1:0]    w_img_base;

  assign w_start_acc  = (r_state == IDLE) && start;
  assign w_issue_last = (r_pix_idx == ADDR_W'(IMG_PIX - 1));
  assign w_beat       = m_valid && m_ready;

  // Credit counts beats already queued plus reads still in the ROM pipeline.
  assign w_pending  = {1'b0, r_vld_p0} + {1'b0, r_vld_p1};
  assign w_inflight = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(w_pending);
  assign w_credit   = !w_fifo_full && (w_inflight < (CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_issue_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_beat && m_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef IMG_SEL_EN
  logic [RA_W-1:0] r_img_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_img_base <= '0;
    end else if (w_start_acc) begin
      r_img_base <= RA_W'(img_sel) * RA_W'(IMG_PIX);
    end
  end

  assign w_img_base = r_img_base;
`else
  assign w_img_base = '0;
`endif

  // p0: address registered toward the ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pix_idx <= '0;
      r_iss_row <= '0;
      r_iss_col <= '0;
      rom_addr  <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld_p0 <= w_issue;
      r_vld_p1 <= r_vld_p0;
      if (w_start_acc) begin
        r_pix_idx <= '0;
        r_iss_row <= '0;
        r_iss_col <= '0;
      end else if (w_issue) begin
        rom_addr  <= w_img_base + RA_W'(r_pix_idx);
        r_pix_idx <= r_pix_idx + ADDR_W'(1);
        if (r_iss_col == RC_W'(IMG_W - 1)) begin
          r_iss_col <= '0;
          r_iss_row <= r_iss_row + RC_W'(1);
        end else begin
          r_iss_col <= r_iss_col + RC_W'(1);
        end
      end
    end
  end

  // p1: tag realigned with the ROM's registered read data
  always_ff @(posedge clk) begin
    if (w_issue)  r_tag_p0 <= {r_iss_row, r_iss_col, w_issue_last};
    if (r_vld_p0) r_tag_p1 <= r_tag_p0;
  end

  // p2: ROM data and its tag written into the FIFO together
  assign w_fifo_din = {rom_data, r_tag_p1};

  img_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_vld_p1),
    .i_din   (w_fifo_din),
    .i_pop   (m_ready),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_valid = !w_fifo_empty;
  assign m_data  = w_fifo_dout[BEAT_W-1 -: DATA_W];
  assign m_row   = w_fifo_dout[TAG_W-1 -: RC_W];
  assign m_col   = w_fifo_dout[RC_W:1];
  assign m_last  = w_fifo_dout[0];

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Scoreboard bench for image_stream_ctrl: a registered ROM model feeds the DUT,
// expected beats are queued at each accepted start and popped on handshakes.
`timescale 1ns/1ps
module tb_image_stream_ctrl;
  import cnn_img_pkg::*;

`ifdef IMG_SEL_EN
  localparam int RA_W = 17;
`else
  localparam int RA_W = 10;
`endif

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   m_ready = 1'b0;
  logic                   busy;
  logic                   done;
  logic                   m_valid;
  logic                   m_last;
  logic [RA_W-1:0]        rom_addr;
  logic signed [7:0]      rom_data;
  logic signed [7:0]      m_data;
  logic [4:0]             m_row;
  logic [4:0]             m_col;
`ifdef IMG_SEL_EN
  logic [6:0]             img_sel = 7'd0;
`endif

  logic signed [7:0] mem [IMG_PIX];
  beat_t             sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int max_cnt  = 0;
  int rdy_mode = 2;
  int start_seq = 0;
  int seen_seq  = 0;
  int start_cyc = 0;
  int first_valid_cyc = 0;
  int last_beat_cyc   = 0;

  bit                exp_done_next = 1'b0;
  bit                prev_stall = 1'b0;
  logic signed [7:0] prev_d;
  logic [4:0]        prev_row;
  logic [4:0]        prev_col;
  logic              prev_last;
  logic [RA_W-1:0]   prev_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= mem[rom_addr % IMG_PIX];

  image_stream_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef IMG_SEL_EN
    .img_sel  (img_sel),
`endif
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_row    (m_row),
    .m_col    (m_col)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 99) < 30);
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall    = 1'b0;
      exp_done_next = 1'b0;
      prev_addr     = rom_addr;
    end else begin
      if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
      if (exp_done_next) check_eq("done_after_last", int'(done), 1);
      exp_done_next = 1'b0;
      if (done) begin
        done_cnt++;
        check_eq("busy_low_in_done", int'(busy), 0);
      end
      if (m_valid && seen_seq != start_seq) begin
        seen_seq        = start_seq;
        first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        check_eq("hold_valid", int'(m_valid), 1);
        check_eq("hold_data", int'(m_data), int'(prev_d));
        check_eq("hold_row", int'(m_row), int'(prev_row));
        check_eq("hold_col", int'(m_col), int'(prev_col));
        check_eq("hold_last", int'(m_last), int'(prev_last));
      end
`ifndef IMG_SEL_EN
      if (rom_addr != prev_addr)
        check_eq("addr_step", int'(rom_addr),
                 (int'(prev_addr) == IMG_PIX - 1) ? 0 : int'(prev_addr) + 1);
`endif
      prev_addr = rom_addr;
      if (m_valid && m_ready) begin
        check_eq("busy_during_stream", int'(busy), 1);
        check_eq("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          beat_t e;
          e = sb_q.pop_front();
          check_eq("beat_data", int'(m_data), e.data);
          check_eq("beat_row", int'(m_row), e.row);
          check_eq("beat_col", int'(m_col), e.col);
          check_eq("beat_last", int'(m_last), e.last);
        end
        beat_cnt++;
        if (m_last) begin
          exp_done_next = 1'b1;
          last_beat_cyc = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_row   = m_row;
      prev_col   = m_col;
      prev_last  = m_last;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_seq++;
    for (int i = 0; i < IMG_PIX; i++)
      sb_q.push_back('{int'(mem[i]), i / IMG_W, i % IMG_W, int'(i == IMG_PIX - 1)});
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, int'(k < budget), 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_addr"}, int'(rom_addr), 0);
    check_eq({tag, "_valid"}, int'(m_valid), 0);
    check_eq({tag, "_last"}, int'(m_last), 0);
    check_eq({tag, "_row"}, int'(m_row), 0);
    check_eq({tag, "_col"}, int'(m_col), 0);
    check_eq({tag, "_data"}, int'(m_data), 0);
  endtask

  initial begin
    int d0, b0, k;
    for (int i = 0; i < IMG_PIX; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: continuous ready, full-rate stream
    rdy_mode = 0;
    d0 = done_cnt; b0 = beat_cnt;
    pulse_start();
    wait_done("t1_done_seen", 2000);
    check_eq("t1_beats", beat_cnt - b0, IMG_PIX);
    check_eq("t1_sb_empty", sb_q.size(), 0);
    check_eq("t1_done_pulses", done_cnt - d0, 1);
    check_eq("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
    check_eq("t1_last_beat_lat", last_beat_cyc - start_cyc, 786);
    check_eq("t1_idle_busy", int'(busy), 0);

    // 2: random backpressure
    rdy_mode = 1;
    d0 = done_cnt; b0 = beat_cnt; max_cnt = 0;
    pulse_start();
    wait_done("t2_done_seen", 20000);
    check_eq("t2_beats", beat_cnt - b0, IMG_PIX);
    check_eq("t2_sb_empty", sb_q.size(), 0);
    check_eq("t2_fifo_max_le4", int'(max_cnt <= 4), 1);
    check_eq("t2_final_addr", int'(rom_addr), IMG_PIX - 1);

    // 3: stray starts mid-image, on the last beat and during DONE
    rdy_mode = 0;
    d0 = done_cnt; b0 = beat_cnt;
    pulse_start();
    k = 0;
    while (!(m_valid && m_row == 5'd0 && m_col == 5'd10) && k < 2000) begin @(negedge clk); k++; end
    check_eq("t3_reach_beat10", int'(k < 2000), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(m_valid && m_last) && k < 2000) begin @(negedge clk); k++; end
    check_eq("t3_reach_last", int'(k < 2000), 1);
    start = 1'b1;
    @(negedge clk);
    check_eq("t3_done_cycle", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t3_done_pulses", done_cnt - d0, 1);
    check_eq("t3_beats", beat_cnt - b0, IMG_PIX);
    check_eq("t3_sb_empty", sb_q.size(), 0);
    check_eq("t3_idle_busy", int'(busy), 0);
    check_eq("t3_idle_valid", int'(m_valid), 0);
    check_eq("t3_addr_held", int'(rom_addr), IMG_PIX - 1);

    // 4: reset mid-image, then restart
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!(m_valid && m_row == 5'd14 && m_col == 5'd8) && k < 2000) begin @(negedge clk); k++; end
    check_eq("t4_reach_beat400", int'(k < 2000), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_abort");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check_eq("t4_no_done_on_abort", done_cnt - d0, 0);
    b0 = beat_cnt;
    pulse_start();
    wait_done("t4_done_seen", 2000);
    check_eq("t4_beats", beat_cnt - b0, IMG_PIX);
    check_eq("t4_sb_empty", sb_q.size(), 0);
    check_eq("t4_done_pulses", done_cnt - d0, 1);

    // 5: ready held low after start
    rdy_mode = 2;
    b0 = beat_cnt;
    pulse_start();
    repeat (50) @(negedge clk);
    check_eq("t5_addr_stalled", int'(rom_addr), 3);
    check_eq("t5_valid", int'(m_valid), 1);
    check_eq("t5_data_mem0", int'(m_data), int'(mem[0]));
    check_eq("t5_row0", int'(m_row), 0);
    check_eq("t5_col0", int'(m_col), 0);
    check_eq("t5_fifo_full", int'(dut.u_fifo.o_count), 4);
    rdy_mode = 0;
    wait_done("t5_done_seen", 2000);
    check_eq("t5_beats", beat_cnt - b0, IMG_PIX);
    check_eq("t5_sb_empty", sb_q.size(), 0);

`ifdef IMG_SEL_EN
    // 6: image select offsets the ROM address
    img_sel = 7'd2;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_first_addr", int'(rom_addr), 1568);
    wait_done("t6_done_seen", 2000);
    check_eq("t6_last_addr", int'(rom_addr), 2351);
    check_eq("t6_sb_empty", sb_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks run, expected run to finish", n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
